// File: rtl/cursor_controller_pkg.sv
// Shared game-phase encoding used by the cursor controller and the game FSM.
package cursor_controller_pkg;

  typedef enum logic [2:0] {
    IDLE_PHASE          = 3'd0,
    PLACEMENT_PHASE     = 3'd1,
    PLAYER_ATTACK_PHASE = 3'd2,
    ENEMY_ATTACK_PHASE  = 3'd3,
    GAME_OVER_PHASE     = 3'd4
  } game_state_t;

endpackage

// File: rtl/cursor_controller.sv
// cursor_controller: synchronizes and debounces the DE-10 buttons, moves a
// clamped cursor over a GRID_SIZE x GRID_SIZE board, tracks ship orientation
// and emits one-cycle place/fire requests.
// Optional: define CURSOR_AUTOREPEAT_EN to add auto-repeat on held move buttons.
module cursor_controller
  import cursor_controller_pkg::*;
#(
  parameter int GRID_SIZE       = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_rotate,
  input  logic        btn_select,
  input  game_state_t game_state,
  input  logic [3:0]  current_ship_length,
  output logic [3:0]  cursor_x,
  output logic [3:0]  cursor_y,
  output logic        orientation,
  output logic        place_pulse,
  output logic        fire_pulse
);

  localparam int UP  = 0;
  localparam int DN  = 1;
  localparam int LF  = 2;
  localparam int RT  = 3;
  localparam int ROT = 4;
  localparam int SEL = 5;
  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);

  logic [5:0]    raw;
  logic [5:0]    sync0;
  logic [5:0]    sync1;
  logic [5:0]    db;
  logic [5:0]    db_prev;
  logic [5:0]    evt;
  logic [3:0]    move_evt;
  logic [CW-1:0] cnt [6];

  assign raw = {btn_select, btn_rotate, btn_right, btn_left, btn_down, btn_up};
  assign evt = db & ~db_prev;

  // Per-button synchronizer, debounce counter and previous-level register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync0   <= '0;
      sync1   <= '0;
      db      <= '0;
      db_prev <= '0;
      for (int unsigned i = 0; i < 6; i++) cnt[i] <= '0;
    end else begin
      sync0   <= raw;
      sync1   <= sync0;
      db_prev <= db;
      for (int unsigned i = 0; i < 6; i++) begin
        if (sync1[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          db[i]  <= sync1[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef CURSOR_AUTOREPEAT_EN
  localparam int ARD = 16 * DEBOUNCE_CYCLES;
  localparam int ARR = 4 * DEBOUNCE_CYCLES;
  localparam int RW  = $clog2(ARD + 1);

  logic [RW-1:0] rcnt [4];
  logic [3:0]    rep;

  // Repeat strobe fires when the hold count reaches the delay.
  always_comb begin
    rep = '0;
    for (int unsigned i = 0; i < 4; i++) rep[i] = db[i] && (rcnt[i] == RW'(ARD));
  end

  // Hold counters: reloading to ARD-ARR+1 makes later repeats ARR cycles apart.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (!reset || !db[i])         rcnt[i] <= '0;
      else if (rcnt[i] == RW'(ARD)) rcnt[i] <= RW'(ARD - ARR + 1);
      else                          rcnt[i] <= rcnt[i] + 1'b1;
    end
  end

  assign move_evt = evt[3:0] | rep;
`else
  assign move_evt = evt[3:0];
`endif

  logic       placing;
  logic       sel;
  logic       rot;
  logic [3:0] mv;
  logic [3:0] len_eff;
  logic       new_orient;
  logic [3:0] max_x;
  logic [3:0] max_y;
  logic [4:0] x_mv;
  logic [4:0] y_mv;
  logic [3:0] next_x;
  logic [3:0] next_y;

  // Next cursor state: rotate, then move, then clamp to the new limits.
  always_comb begin
    placing    = (game_state == PLACEMENT_PHASE);
    sel        = evt[SEL];
    rot        = evt[ROT] & placing & ~sel;
    mv         = move_evt & {4{~sel}};
    new_orient = orientation ^ rot;

    if (current_ship_length == 4'd0)                   len_eff = 4'd1;
    else if (current_ship_length > 4'(GRID_SIZE))      len_eff = 4'(GRID_SIZE);
    else                                               len_eff = current_ship_length;

    max_x = 4'(GRID_SIZE - 1);
    max_y = 4'(GRID_SIZE - 1);
    if (placing) begin
      if (new_orient) max_y = 4'(GRID_SIZE) - len_eff;
      else            max_x = 4'(GRID_SIZE) - len_eff;
    end

    x_mv = {1'b0, cursor_x};
    if (mv[LF] && !mv[RT])      x_mv = (cursor_x == 4'd0) ? 5'd0 : x_mv - 5'd1;
    else if (mv[RT] && !mv[LF]) x_mv = x_mv + 5'd1;

    y_mv = {1'b0, cursor_y};
    if (mv[UP] && !mv[DN])      y_mv = (cursor_y == 4'd0) ? 5'd0 : y_mv - 5'd1;
    else if (mv[DN] && !mv[UP]) y_mv = y_mv + 5'd1;

    next_x = (x_mv > {1'b0, max_x}) ? max_x : x_mv[3:0];
    next_y = (y_mv > {1'b0, max_y}) ? max_y : y_mv[3:0];
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cursor_x    <= '0;
      cursor_y    <= '0;
      orientation <= 1'b0;
      place_pulse <= 1'b0;
      fire_pulse  <= 1'b0;
    end else begin
      cursor_x    <= next_x;
      cursor_y    <= next_y;
      orientation <= new_orient;
      place_pulse <= sel & placing;
      fire_pulse  <= sel & ~placing;
    end
  end

endmodule
